// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch port and the
// load/store port. Define ARB_TIMEOUT_EN to add a mem_ready timeout with bus_err.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall_if,
  output logic              stall_d,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err,
  output logic [1:0]        dbg_state
);

  // Handshakes: a requester raises x_req with stable fields and holds it until its
  // one-cycle x_valid; mem_req and the mem_* fields stay stable until mem_ready.

  if (TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("mem_port_arbiter: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_d_q;   // 1: the data port won the most recent grant
  logic   kill_q;
  logic   grant_i, grant_d;
  logic   done, tmo_hit, finish, kill_now;

  // Data wins a tie unless it also won last time.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state_q == IDLE) begin
      grant_d = d_req & ~(if_req & last_d_q);
      grant_i = if_req & ~grant_d;
    end
  end

  assign done     = (state_q != IDLE) & mem_ready;
  assign finish   = done | tmo_hit;
  assign kill_now = kill_q | if_flush;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             bus_err_q;

  // A mem_ready in the final waiting cycle still completes normally.
  assign tmo_hit = (state_q != IDLE) & ~mem_ready & (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= tmo_hit;
      if (state_q == IDLE || finish) tmo_cnt_q <= '0;
      else                           tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign tmo_hit = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d)      state_d = BUSY_D;
        else if (grant_i) state_d = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (finish) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // kill marks a fetch squashed by a redirect; the memory access still finishes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d_q <= 1'b0;
      kill_q   <= 1'b0;
    end else begin
      if (grant_d)      last_d_q <= 1'b1;
      else if (grant_i) last_d_q <= 1'b0;

      if (grant_i)                kill_q <= if_flush;
      else if (state_q == BUSY_I) kill_q <= finish ? 1'b0 : kill_now;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      d_valid   <= 1'b0;
      d_rdata   <= '0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;

      if (grant_d) begin
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (grant_i) begin
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
      end

      if (finish && state_q == BUSY_I && !kill_now) begin
        if_valid <= 1'b1;
        if_rdata <= done ? mem_rdata : '0;
      end

      if (finish && state_q == BUSY_D) begin
        d_valid <= 1'b1;
        d_rdata <= (done && !mem_we) ? mem_rdata : '0;
      end
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign stall_if  = if_req & ~if_valid;
  assign stall_d   = d_req & ~d_valid;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic, compared every
// cycle against a transaction-level model of the arbiter kept in the bench.
module tb_mem_port_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TMO    = 4;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 16;
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk, rst;
  logic        if_req, if_flush, if_valid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_valid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        stall_if, stall_d;
  logic        mem_req, mem_we, mem_ready, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  int total, bad;
  bit chk_en, rand_mode, rand_lat, fix_en, stray_en;
  int mem_lat, mem_cnt;
  logic [31:0] fix_data;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .stall_if(stall_if), .stall_d(stall_d),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .bus_err(bus_err), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int          owner;        // 0 nobody, 1 fetch, 2 data
  bit          data_won_last;
  bit          squash;
  int          waited;
  logic        e_mem_we;
  logic [31:0] e_mem_addr, e_mem_wdata;
  logic        e_if_valid, e_d_valid, e_bus_err;
  logic [31:0] e_if_rdata, e_d_rdata;
  logic [31:0] exp_q[$];     // expected d_rdata of each data completion

  task automatic model_complete(input logic [31:0] data, input bit err);
    if (owner == 1) begin
      if (!squash) begin
        e_if_valid = 1'b1;
        e_if_rdata = data;
      end
      squash = 1'b0;
    end else begin
      e_d_valid = 1'b1;
      e_d_rdata = e_mem_we ? 32'h0 : data;
      exp_q.push_back(e_d_rdata);
    end
    e_bus_err = err;
    owner     = 0;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner = 0; data_won_last = 1'b0; squash = 1'b0; waited = 0;
      e_mem_we = 1'b0; e_mem_addr = '0; e_mem_wdata = '0;
      e_if_valid = 1'b0; e_d_valid = 1'b0; e_bus_err = 1'b0;
      e_if_rdata = '0; e_d_rdata = '0;
      exp_q.delete();
    end else begin
      e_if_valid = 1'b0;
      e_d_valid  = 1'b0;
      e_bus_err  = 1'b0;
      if (owner == 0) begin
        waited = 0;
        if (d_req && !(if_req && data_won_last)) begin
          owner = 2; data_won_last = 1'b1;
          e_mem_addr = d_addr; e_mem_we = d_we; e_mem_wdata = d_wdata;
        end else if (if_req) begin
          owner = 1; data_won_last = 1'b0;
          e_mem_addr = if_addr; e_mem_we = 1'b0; e_mem_wdata = '0;
          squash = if_flush;
        end
      end else begin
        waited++;
        if (owner == 1 && if_flush) squash = 1'b1;
        if (mem_ready)                      model_complete(mem_rdata, 1'b0);
        else if (TMO_EN && waited == TMO)   model_complete(32'h0, 1'b1);
      end
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_req", mem_req, owner != 0);
      check("if_valid", if_valid, e_if_valid);
      check("d_valid", d_valid, e_d_valid);
      check("if_rdata", if_rdata, e_if_rdata);
      check("d_rdata", d_rdata, e_d_rdata);
      check("bus_err", bus_err, e_bus_err);
      check("stall_if", stall_if, if_req & ~e_if_valid);
      check("stall_d", stall_d, d_req & ~e_d_valid);
      if (owner != 0) begin
        check("mem_addr", mem_addr, e_mem_addr);
        check("mem_we", mem_we, e_mem_we);
        if (e_mem_we) check("mem_wdata", mem_wdata, e_mem_wdata);
      end
      if (d_valid) begin
        if (exp_q.size() == 0) check("d_valid_unexpected", 1, 0);
        else check("d_rdata_q", d_rdata, exp_q.pop_front());
      end
    end
  end

  // ---------------- memory responder ----------------
  always @(posedge clk) begin
    #2;
    if (mem_req) begin
      if (mem_cnt == 0 && rand_lat) mem_lat = $urandom_range(0, 5);
      mem_ready = (mem_lat >= 0) && (mem_cnt >= mem_lat);
      mem_cnt++;
    end else begin
      mem_cnt   = 0;
      mem_ready = stray_en && ($urandom_range(0, 3) == 0);
    end
    mem_rdata = fix_en ? fix_data : $urandom;
  end

  // ---------------- random requester driver ----------------
  always @(posedge clk) begin
    #1;
    if (rand_mode && rst) begin
      if (if_valid || !if_req) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = $urandom & 32'hFFFF_FFFC;
      end else if ($urandom_range(0, 63) == 0) begin
        if_req = 1'b0;
      end
      if_flush = ($urandom_range(0, 9) == 0);
      if (if_flush) if_addr = $urandom & 32'hFFFF_FFFC;
      if (d_valid || !d_req) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = ($urandom_range(0, 1) == 1);
        d_addr  = $urandom & 32'hFFFF_FFFC;
        d_wdata = $urandom;
      end else if ($urandom_range(0, 63) == 0) begin
        d_req = 1'b0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequences, then random, then report ----------------
  initial begin
    total = 0; bad = 0; chk_en = 1'b0; rand_mode = 1'b0; rand_lat = 1'b0;
    fix_en = 1'b1; fix_data = '0; stray_en = 1'b0; mem_lat = 0; mem_cnt = 0;
    mem_ready = 1'b0; mem_rdata = '0;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_d_valid", d_valid, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_bus_err", bus_err, 0);
    next_cycle();
    rst = 1'b1;
    chk_en = 1'b1;
    next_cycle();

    // fetch only, zero-wait memory
    if_req = 1'b1; if_addr = 32'h0000_0010; mem_lat = 0; fix_data = 32'h0050_0093;
    @(negedge clk);
    check("t1_stall_a", stall_if, 1);
    check("t1_mem_req_a", mem_req, 0);
    next_cycle();
    @(negedge clk);
    check("t1_mem_req_b", mem_req, 1);
    check("t1_mem_addr", mem_addr, 32'h0000_0010);
    check("t1_stall_b", stall_if, 1);
    next_cycle();
    if_req = 1'b0;
    @(negedge clk);
    check("t1_if_valid", if_valid, 1);
    check("t1_if_rdata", if_rdata, 32'h0050_0093);
    check("t1_stall_c", stall_if, 0);
    check("t1_mem_req_c", mem_req, 0);
    next_cycle();
    @(negedge clk);
    check("t1_if_valid_off", if_valid, 0);
    next_cycle();

    // simultaneous requests: data first, then round-robin favours fetch
    if_req = 1'b1; if_addr = 32'h0000_0040;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0100; fix_data = 32'h1111_1111;
    next_cycle();
    @(negedge clk);
    check("t2_first_addr", mem_addr, 32'h0000_0100);
    next_cycle();
    d_addr = 32'h0000_0104; fix_data = 32'h2222_2222;
    @(negedge clk);
    check("t2_d_valid", d_valid, 1);
    check("t2_d_rdata", d_rdata, 32'h1111_1111);
    next_cycle();
    @(negedge clk);
    check("t2_fetch_next", mem_addr, 32'h0000_0040);
    check("t2_fetch_we", mem_we, 0);
    next_cycle();
    if_req = 1'b0; fix_data = 32'h3333_3333;
    @(negedge clk);
    check("t2_if_rdata", if_rdata, 32'h2222_2222);
    next_cycle();
    @(negedge clk);
    check("t2_data_second", mem_addr, 32'h0000_0104);
    next_cycle();
    d_req = 1'b0;
    @(negedge clk);
    check("t2_d_rdata2", d_rdata, 32'h3333_3333);
    next_cycle();

    // flush during a 2-cycle fetch
    if_req = 1'b1; if_addr = 32'h0000_0080; mem_lat = 1; fix_data = 32'h4444_4444;
    next_cycle();
    if_flush = 1'b1; if_addr = 32'h0000_00C0;
    @(negedge clk);
    check("t3_old_addr", mem_addr, 32'h0000_0080);
    next_cycle();
    if_flush = 1'b0;
    @(negedge clk);
    check("t3_mem_req_held", mem_req, 1);
    next_cycle();
    fix_data = 32'h5555_5555; mem_lat = 0;
    @(negedge clk);
    check("t3_no_if_valid", if_valid, 0);
    check("t3_if_rdata_kept", if_rdata, 32'h2222_2222);
    next_cycle();
    @(negedge clk);
    check("t3_new_pc", mem_addr, 32'h0000_00C0);
    next_cycle();
    if_req = 1'b0;
    @(negedge clk);
    check("t3_if_valid", if_valid, 1);
    check("t3_if_rdata", if_rdata, 32'h5555_5555);
    next_cycle();

    // store with 3 wait cycles
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0200; d_wdata = 32'hDEAD_BEEF;
    mem_lat = 3; fix_data = 32'h6666_6666;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      check("t4_mem_req", mem_req, 1);
      check("t4_mem_we", mem_we, 1);
      check("t4_mem_addr", mem_addr, 32'h0000_0200);
      check("t4_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    end
    next_cycle();
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    check("t4_d_valid", d_valid, 1);
    check("t4_d_rdata", d_rdata, 0);
    next_cycle();

    // asynchronous reset in the middle of a data access
    d_req = 1'b1; d_addr = 32'h0000_0300; mem_lat = -1;
    next_cycle();
    #2;
    check("t5_busy", mem_req, 1);
    rst = 1'b0; d_req = 1'b0;
    #1;
    check("t5_mem_req", mem_req, 0);
    check("t5_mem_addr", mem_addr, 0);
    check("t5_mem_we", mem_we, 0);
    check("t5_if_rdata", if_rdata, 0);
    check("t5_d_rdata", d_rdata, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    check("t5_idle_after", mem_req, 0);
    next_cycle();

`ifdef ARB_TIMEOUT_EN
    // memory never answers
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0400; mem_lat = -1; fix_data = 32'h7777_7777;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      check("t6_mem_req", mem_req, 1);
      check("t6_no_err", bus_err, 0);
    end
    next_cycle();
    d_req = 1'b0;
    @(negedge clk);
    check("t6_bus_err", bus_err, 1);
    check("t6_d_valid", d_valid, 1);
    check("t6_d_rdata", d_rdata, 0);
    check("t6_mem_req_off", mem_req, 0);
    next_cycle();
    @(negedge clk);
    check("t6_err_pulse", bus_err, 0);
    next_cycle();
`endif

    // randomized traffic
    rand_lat = 1'b1; fix_en = 1'b0; stray_en = 1'b1; mem_lat = 0;
    rand_mode = 1'b1;
    repeat (3000) @(posedge clk);
    @(negedge clk);
    rand_mode = 1'b0;
    next_cycle();
    if_req = 1'b0; d_req = 1'b0; if_flush = 1'b0; stray_en = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("drain_exp_q", exp_q.size(), 0);
    check("drain_mem_req", mem_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
